// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: line-request port plus physical-memory burst port
interface cacheline_adaptor_if;
  logic         line_read_i;
  logic         line_write_i;
  logic [31:0]  line_addr_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         line_resp_o;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [31:0]  burst_addr_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         burst_resp_i;
  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_i, burst_i, burst_resp_i,
    output line_o, line_resp_o, burst_read_o, burst_write_o, burst_addr_o, burst_o
  );
  modport master (
    output line_read_i, line_write_i, line_addr_i, line_i, burst_i, burst_resp_i,
    input  line_o, line_resp_o, burst_read_o, burst_write_o, burst_addr_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: runs one 256-bit line request as a 4-beat 64-bit memory burst
module cacheline_adaptor (
  input  logic               clk,
  input  logic               reset_n,
  cacheline_adaptor_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0]   r_state;
  logic [1:0]   r_cnt;
  logic [31:5]  r_addr;
  logic [255:0] r_buf;
  logic         w_beat;
  logic         w_last;
  // memory strobes only count while a burst is actually in flight
  assign w_beat = bus.burst_resp_i && (r_state == READ || r_state == WRITE);
  assign w_last = w_beat && r_cnt == 2'd3;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (bus.line_read_i) begin
            r_state <= READ;
            r_addr  <= bus.line_addr_i[31:5];
          end else if (bus.line_write_i) begin
            r_state <= WRITE;
            r_addr  <= bus.line_addr_i[31:5];
            r_buf   <= bus.line_i;
          end
        READ: begin
          if (w_beat) r_buf[{r_cnt, 6'd0} +: 64] <= bus.burst_i;
          if (w_last) r_state <= DONE;
        end
        WRITE: if (w_last) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
      if (w_beat) r_cnt <= r_cnt + 2'd1;
    end
  assign bus.burst_read_o  = r_state == READ;
  assign bus.burst_write_o = r_state == WRITE;
  assign bus.line_resp_o   = r_state == DONE;
  assign bus.line_o        = r_buf;
  assign bus.burst_addr_o  = {r_addr, 5'd0};
  assign bus.burst_o       = r_state == WRITE ? r_buf[{r_cnt, 6'd0} +: 64] : 64'd0;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: table-driven line transactions plus back-to-back and reset-abort sequences
module tb_cacheline_adaptor;
  logic clk;
  logic reset_n;
  int checks = 0;
  int failures = 0;
  cacheline_adaptor_if bus ();
  cacheline_adaptor dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] din;
    logic [255:0] mem;
    logic [7:0]   pat;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
  } vec_t;
  vec_t vt [6];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // Starts at a negedge with the DUT idle; sampling and driving both happen on negedges.
  task automatic run(input vec_t v);
    int nb = 0;
    int c = 0;
    logic r;
    bus.line_read_i  = v.rd;
    bus.line_write_i = v.wr;
    bus.line_addr_i  = v.addr;
    bus.line_i       = v.din;
    bus.burst_resp_i = 1'b0;
    @(negedge clk);
    while (nb < 4 && c < 20) begin
      c++;
      chk("burst_read", bus.burst_read_o, v.rd);
      chk("burst_write", bus.burst_write_o, !v.rd);
      chk("burst_addr", bus.burst_addr_o, v.exp_addr);
      chk("resp_early", bus.line_resp_o, 0);
      if (!v.rd) chk("burst_o", bus.burst_o, v.din[64*nb +: 64]);
      if (c == 1) begin
        bus.line_read_i  = 1'b0;
        bus.line_write_i = 1'b0;
        bus.line_addr_i  = 32'hDEAD_BEEF;
        bus.line_i       = {4{64'hFFFF_0000_FFFF_0000}};
      end
      r = (c <= 8) ? v.pat[c-1] : 1'b1;
      bus.burst_resp_i = r;
      bus.burst_i = r ? v.mem[64*nb +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (r) nb++;
      @(negedge clk);
    end
    if (nb < 4) chk("beat_budget", nb, 4);
    chk("resp_pulse", bus.line_resp_o, 1);
    chk("line_o", bus.line_o, v.exp_line);
    chk("done_no_burst", {bus.burst_read_o, bus.burst_write_o}, 0);
    bus.burst_resp_i = 1'b1;
    bus.burst_i = 64'hBAD1_BAD1_BAD1_BAD1;
    @(negedge clk);
    chk("resp_single", bus.line_resp_o, 0);
    chk("line_o_held", bus.line_o, v.exp_line);
    chk("idle_no_burst", {bus.burst_read_o, bus.burst_write_o}, 0);
    bus.burst_resp_i = 1'b0;
  endtask
  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'd0,
              {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
              8'hFF, 32'h0000_1220,
              {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111}};
    vt[1] = '{1'b0, 1'b1, 32'h8000_003F, {64'hD, 64'hC, 64'hB, 64'hA}, 256'd0,
              8'hFF, 32'h8000_0020, {64'hD, 64'hC, 64'hB, 64'hA}};
    vt[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 256'd0,
              {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A},
              8'h59, 32'hFFFF_FFE0,
              {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A}};
    vt[3] = '{1'b0, 1'b1, 32'h1234_5660,
              {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555},
              256'd0, 8'h6D, 32'h1234_5660,
              {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555}};
    vt[4] = '{1'b1, 1'b1, 32'h0000_0047, {4{64'hFFFFFFFFFFFFFFFF}},
              {64'hC0DE_0003, 64'hC0DE_0002, 64'hC0DE_0001, 64'hC0DE_0000},
              8'hFF, 32'h0000_0040,
              {64'hC0DE_0003, 64'hC0DE_0002, 64'hC0DE_0001, 64'hC0DE_0000}};
    vt[5] = '{1'b1, 1'b0, 32'h0000_3000, 256'd0,
              {64'h4, 64'h3, 64'h2, 64'h1}, 8'hFF, 32'h0000_3000,
              {64'h4, 64'h3, 64'h2, 64'h1}};
    reset_n = 1'b0;
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.line_addr_i  = 32'd0;
    bus.line_i       = 256'd0;
    bus.burst_i      = 64'd0;
    bus.burst_resp_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_line_o", bus.line_o, 0);
    chk("rst_resp", bus.line_resp_o, 0);
    chk("rst_burst_rw", {bus.burst_read_o, bus.burst_write_o}, 0);
    chk("rst_addr", bus.burst_addr_o, 0);
    chk("rst_burst_o", bus.burst_o, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run(vt[i]);
    // back-to-back: read held high through the response relatches a new address
    bus.line_read_i = 1'b1;
    bus.line_addr_i = 32'h0000_0100;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus.burst_resp_i = 1'b1;
      bus.burst_i = 64'h1000 + 64'(k);
      @(negedge clk);
    end
    chk("b2b_resp1", bus.line_resp_o, 1);
    chk("b2b_line1", bus.line_o, {64'h1003, 64'h1002, 64'h1001, 64'h1000});
    bus.burst_resp_i = 1'b0;
    bus.line_addr_i = 32'h0000_2345;
    @(negedge clk);
    chk("b2b_idle", {bus.line_resp_o, bus.burst_read_o}, 0);
    @(negedge clk);
    chk("b2b_read2", bus.burst_read_o, 1);
    chk("b2b_addr2", bus.burst_addr_o, 32'h0000_2340);
    bus.line_read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.burst_resp_i = 1'b1;
      bus.burst_i = 64'h2000 + 64'(k);
      @(negedge clk);
    end
    chk("b2b_resp2", bus.line_resp_o, 1);
    chk("b2b_line2", bus.line_o, {64'h2003, 64'h2002, 64'h2001, 64'h2000});
    bus.burst_resp_i = 1'b0;
    @(negedge clk);
    // reset after two beats aborts the burst with no response
    bus.line_read_i = 1'b1;
    bus.line_addr_i = 32'h0000_7700;
    @(negedge clk);
    bus.line_read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.burst_resp_i = 1'b1;
      bus.burst_i = 64'h7700 + 64'(k);
      @(negedge clk);
    end
    bus.burst_resp_i = 1'b0;
    chk("abort_pre_read", bus.burst_read_o, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_line_o", bus.line_o, 0);
    chk("abort_resp", bus.line_resp_o, 0);
    chk("abort_burst_rw", {bus.burst_read_o, bus.burst_write_o}, 0);
    chk("abort_addr", bus.burst_addr_o, 0);
    chk("abort_burst_o", bus.burst_o, 0);
    for (int k = 0; k < 2; k++) begin
      bus.burst_resp_i = 1'b1;
      @(negedge clk);
      chk("abort_no_resp", bus.line_resp_o, 0);
    end
    bus.burst_resp_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {bus.line_resp_o, bus.burst_read_o}, 0);
    run(vt[5]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Responder at the far end of the arbiter's line-memory port: accepts a single 256-bit cacheline read or write request and carries it out as a 4-beat, 64-bit burst against physical memory. It latches the request, runs the burst, then returns one line response pulse. It sits between the cache arbiter / L2 line port and the physical memory burst interface.

## Interface
Parameters: none. Widths are fixed: 256-bit line, 64-bit beat, 4 beats, 32-bit address.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- line_read_i  in  1  line read request from the arbiter
- line_write_i  in  1  line write request from the arbiter
- line_addr_i  in  32  line address; bits [4:0] are ignored
- line_i  in  256  write data, sampled only at request acceptance
- line_o  out  256  read data; valid while line_resp_o=1 and held afterwards
- line_resp_o  out  1  one-cycle completion pulse
- burst_read_o  out  1  memory burst read request
- burst_write_o  out  1  memory burst write request
- burst_addr_o  out  32  {latched_addr[31:5], 5'b0}; stable for the whole burst
- burst_o  out  64  current write beat
- burst_i  in  64  read beat from memory
- burst_resp_i  in  1  memory beat strobe; one beat per cycle while high

## Operation
- State machine: IDLE, READ, WRITE, DONE.
- IDLE, on acceptance:
  - If line_read_i=1: latch line_addr_i, go to READ. Read has priority when both requests are high.
  - Else if line_write_i=1: latch line_addr_i and line_i into the 256-bit buffer, go to WRITE.
- READ:
  - burst_read_o=1.
  - Each cycle with burst_resp_i=1: buffer[64*cnt +: 64] <= burst_i, then cnt <= cnt+1.
  - On the beat where cnt==3, go to DONE.
- WRITE:
  - burst_write_o=1 and burst_o=buffer[64*cnt +: 64].
  - Each cycle with burst_resp_i=1: cnt <= cnt+1.
  - On the beat where cnt==3, go to DONE.
- DONE:
  - line_resp_o=1 for exactly one cycle, with line_o=buffer.
  - Go to IDLE; cnt is 0 at this point.
- Beat order is ascending: beat 0 = line[63:0], beat 3 = line[255:192].
- cnt is 2 bits and wraps 3→0 on the final beat.
- burst_read_o and burst_write_o are decoded from state only. They are never high together and never high in IDLE or DONE.
- Once a request is accepted it is latched. Dropping or changing line_read_i, line_write_i, line_addr_i or line_i mid-transaction has no effect.
- burst_resp_i is ignored in IDLE and DONE.
- burst_resp_i may drop between beats; the transfer stalls with cnt held.
- The requester deasserts its request in the cycle after line_resp_o. A request still high in IDLE starts a new transaction (back-to-back is legal).
- line_o holds the last buffer contents until the next transaction overwrites the buffer.
  - A write overwrites the buffer with line_i at acceptance, so after a write completes, line_o equals the written line.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, cnt=0, buffer=0. All outputs are 0: line_o, line_resp_o, burst_read_o, burst_write_o, burst_addr_o, burst_o.
- Reset mid-burst aborts immediately. No line_resp_o is issued and the burst request drops in the same cycle.
- Request sampled at edge 0 → burst request is high from cycle 1.
- With beats at cycles t..t+3, line_resp_o=1 at cycle t+4.
- Minimum request-to-response latency is 5 cycles (beats at cycles 1–4, response at cycle 5).
- burst_addr_o, and burst_o within a beat, change only on clock edges. Both come from registers or cnt, with no combinational path from burst_resp_i.

## Test plan
- Read: line_read_i=1, addr=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles.
  - Required: burst_addr_o=0x0000_1220.
  - Required: line_resp_o at cycle 5, line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write: line_write_i=1, line_i = {64'hD, 64'hC, 64'hB, 64'hA}.
  - Required: burst_write_o=1 and burst_o = A, B, C, D on successive resp cycles.
  - Required: one line_resp_o pulse, then IDLE.
- Gapped beats: burst_resp_i pattern 1,0,0,1,1,0,1.
  - Required: cnt holds during the gaps and line_resp_o comes exactly one cycle after the 4th strobe.
  - Required: buffer contents are correct.
- Simultaneous read and write plus request drop:
  - Both requests high at acceptance → the READ path is taken.
  - Dropping line_read_i in cycle 2 → the burst still completes and line_resp_o still pulses.
- Back-to-back: line_read_i held high through line_resp_o → a second READ starts on the following cycle, and burst_addr_o is relatched.
- Reset mid-burst: reset_n=0 after 2 beats.
  - Required: all outputs 0 immediately and no line_resp_o.
  - Required: a subsequent read completes normally with cnt starting from 0.
